// File: rtl/parking_gate_ctrl.sv
// Parking barrier controller: single gate shared by entry and exit, with occupancy tracking.
// Latency: every output is registered and moves one clk after the causing input edge or tick.
// Backpressure: none; requests are levels and are sampled while IDLE, a full lot refuses entry.
module parking_gate_ctrl #(
    parameter int CAPACITY  = 8,
    parameter int MOVE_SECS = 2,
    parameter int OPEN_SECS = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk_1Hz,
    input  logic       clk_2Hz,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic       car_passed,
    input  logic       obstruct,
    output logic       gate_open,
    output logic [1:0] motor,
    output logic       lamp,
    output logic [3:0] occupancy,
    output logic       full,
    output logic       denied
);

    localparam logic [3:0] CAP  = 4'(CAPACITY);
    localparam logic [3:0] MOVE = 4'(MOVE_SECS);
    localparam logic [3:0] HOLD = 4'(OPEN_SECS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } state_t;

    state_t     state, state_nx;
    logic [3:0] timer, timer_nx;
    logic       dir, dir_nx;
    logic [3:0] occ_nx;
    logic       deny_lock, deny_lock_nx;
    logic       denied_nx;
    logic       lamp_nx;
    logic [1:0] motor_nx;

    logic c1_q, c2_q, pass_q;
    logic tick1, tick2, pass_evt;

    assign tick1    = clk_1Hz & ~c1_q;
    assign tick2    = clk_2Hz & ~c2_q;
    assign pass_evt = car_passed & ~pass_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c1_q   <= 1'b0;
            c2_q   <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            c1_q   <= clk_1Hz;
            c2_q   <= clk_2Hz;
            pass_q <= car_passed;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            timer     <= 4'd0;
            dir       <= 1'b0;
            deny_lock <= 1'b0;
            gate_open <= 1'b0;
            motor     <= 2'b00;
            lamp      <= 1'b0;
            occupancy <= 4'd0;
            full      <= 1'b0;
            denied    <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            dir       <= dir_nx;
            deny_lock <= deny_lock_nx;
            gate_open <= (state_nx == OPEN);
            motor     <= motor_nx;
            lamp      <= lamp_nx;
            occupancy <= occ_nx;
            full      <= (occ_nx == CAP);
            denied    <= denied_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        timer_nx     = timer;
        dir_nx       = dir;
        occ_nx       = occupancy;
        deny_lock_nx = deny_lock & entry_req;
        denied_nx    = 1'b0;
        lamp_nx      = 1'b0;
        motor_nx     = 2'b00;

        case (state)
            IDLE: begin
                if (exit_req && occupancy != 4'd0) begin
                    state_nx = OPENING;
                    timer_nx = MOVE;
                    dir_nx   = 1'b1;
                end else if (entry_req && !full) begin
                    state_nx = OPENING;
                    timer_nx = MOVE;
                    dir_nx   = 1'b0;
                end else if (entry_req && full && !exit_req && !deny_lock) begin
                    // One refusal per held request; re-armed when entry_req drops.
                    denied_nx    = 1'b1;
                    deny_lock_nx = 1'b1;
                end
            end
            OPENING: begin
                if (tick1) begin
                    if (timer <= 4'd1) begin
                        state_nx = OPEN;
                        timer_nx = HOLD;
                    end else begin
                        timer_nx = timer - 4'd1;
                    end
                end
            end
            OPEN: begin
                if (pass_evt) begin
                    if (!dir && occupancy < CAP)
                        occ_nx = occupancy + 4'd1;
                    else if (dir && occupancy != 4'd0)
                        occ_nx = occupancy - 4'd1;
                    state_nx = CLOSING;
                    timer_nx = MOVE;
                end else if (tick1) begin
                    if (timer <= 4'd1) begin
                        state_nx = CLOSING;
                        timer_nx = MOVE;
                    end else begin
                        timer_nx = timer - 4'd1;
                    end
                end
            end
            CLOSING: begin
                // A reopen keeps dir so a car still under the gate is counted correctly.
                if (obstruct) begin
                    state_nx = OPENING;
                    timer_nx = MOVE;
                end else if (tick1) begin
                    if (timer <= 4'd1) begin
                        state_nx = IDLE;
                        timer_nx = 4'd0;
                    end else begin
                        timer_nx = timer - 4'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        case (state_nx)
            OPENING, CLOSING: begin
                motor_nx = (state_nx == OPENING) ? 2'b01 : 2'b10;
                lamp_nx  = (state_nx != state) ? 1'b1 : (lamp ^ tick2);
            end
            OPEN:    lamp_nx = 1'b1;
            default: lamp_nx = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Randomized gate transactions; a monitor checks each completed gate cycle against queued expectations.
module tb_parking_gate_ctrl;

    localparam int CAP  = 2;
    localparam int MOVE = 2;
    localparam int HOLD = 3;
    localparam int T1   = 16;
    localparam int T2   = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clk_1Hz = 1'b0;
    logic       clk_2Hz = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic       car_passed = 1'b0;
    logic       obstruct = 1'b0;
    logic       gate_open;
    logic [1:0] motor;
    logic       lamp;
    logic [3:0] occupancy;
    logic       full;
    logic       denied;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_occ = 0;

    typedef struct {
        bit deny;
        int occ;
        bit full;
        int phases;
        int open_ticks;
    } exp_t;

    exp_t expq[$];

    parking_gate_ctrl #(.CAPACITY(CAP), .MOVE_SECS(MOVE), .OPEN_SECS(HOLD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_1Hz    (clk_1Hz),
        .clk_2Hz    (clk_2Hz),
        .entry_req  (entry_req),
        .exit_req   (exit_req),
        .car_passed (car_passed),
        .obstruct   (obstruct),
        .gate_open  (gate_open),
        .motor      (motor),
        .lamp       (lamp),
        .occupancy  (occupancy),
        .full       (full),
        .denied     (denied)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            clk_1Hz = ((cyc % T1) >= T1 / 2);
            clk_2Hz = ((cyc % T2) >= T2 / 2);
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    bit         active = 0;
    bit         have_prev = 0;
    int         phases = 0;
    int         tk_ph = 0;
    int         tk_open = 0;
    int         tk_close = 0;
    logic       c1p = 1'b0, c2p = 1'b0, pt2 = 1'b0, pgate = 1'b0, plamp = 1'b0, pobs = 1'b0;
    logic [1:0] pmotor = 2'b00;
    logic       t1, t2;
    exp_t       e;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                active = 0; have_prev = 0; phases = 0;
                c1p = 1'b0; c2p = 1'b0; pmotor = 2'b00; pgate = 1'b0;
            end else begin
                t1 = clk_1Hz && !c1p;
                t2 = clk_2Hz && !c2p;
                chk("motor_legal", int'(motor != 2'b11 && !(gate_open && motor != 2'b00)), 1);
                if (have_prev) begin
                    if (gate_open)
                        chk("lamp_open", int'(lamp), 1);
                    else if (motor == 2'b00)
                        chk("lamp_idle", int'(lamp), 0);
                    else if (motor != pmotor)
                        chk("lamp_move_start", int'(lamp), 1);
                    else
                        chk("lamp_blink", int'(lamp), int'(pt2 ? !plamp : plamp));
                    if (pobs && pmotor == 2'b10)
                        chk("obstruct_reopen", int'(motor), 1);
                end
                if (motor == 2'b01 && pmotor != 2'b01) begin
                    phases = phases + 1; active = 1; tk_ph = 0;
                end
                if (pmotor == 2'b01 && motor != 2'b01)
                    chk("opening_ticks", tk_ph, MOVE);
                if (gate_open && !pgate)
                    tk_open = 0;
                if (motor == 2'b10 && pmotor != 2'b10)
                    tk_close = 0;
                if (pmotor == 2'b10 && motor == 2'b00)
                    chk("closing_ticks", tk_close, MOVE);
                if (t1) begin
                    if (motor == 2'b01) tk_ph = tk_ph + 1;
                    if (gate_open)      tk_open = tk_open + 1;
                    if (motor == 2'b10) tk_close = tk_close + 1;
                end
                if (active && motor == 2'b00 && !gate_open) begin
                    active = 0;
                    if (expq.size() == 0) begin
                        chk("unexpected_gate_cycle", phases, 0);
                    end else begin
                        e = expq.pop_front();
                        chk("cycle_kind", int'(e.deny), 0);
                        chk("occupancy", int'(occupancy), e.occ);
                        chk("full", int'(full), int'(e.full));
                        chk("open_phases", phases, e.phases);
                        if (e.open_ticks >= 0)
                            chk("open_hold_ticks", tk_open, e.open_ticks);
                    end
                    phases = 0;
                end
                if (denied) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_denied", int'(denied), 0);
                    end else begin
                        e = expq.pop_front();
                        chk("denied_kind", int'(e.deny), 1);
                        chk("denied_motor", int'(motor), 0);
                    end
                end
                pmotor = motor; pgate = gate_open; plamp = lamp; pt2 = t2; pobs = obstruct;
                c1p = clk_1Hz; c2p = clk_2Hz; have_prev = 1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input int what, input int bound, input string nm);
        bit ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(posedge clk);
            #1;
            case (what)
                0:       ok = (motor == 2'b01);
                1:       ok = gate_open;
                2:       ok = (motor == 2'b10);
                default: ok = (motor == 2'b00 && !gate_open);
            endcase
        end
        chk(nm, int'(ok), 1);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_gate_open"}, int'(gate_open), 0);
        chk({nm, "_motor"}, int'(motor), 0);
        chk({nm, "_lamp"}, int'(lamp), 0);
        chk({nm, "_occupancy"}, int'(occupancy), 0);
        chk({nm, "_full"}, int'(full), 0);
        chk({nm, "_denied"}, int'(denied), 0);
    endtask

    // kind: 0 entry+car, 1 entry timeout, 2 exit+car, 3 both requests, 4 obstruction, 5 entry attempt
    task automatic do_txn(input int kind);
        bit   e_r = 0, x_r = 0, pass = 1, obs = 0, spur = 0;
        int   nocc;
        exp_t r;
        case (kind)
            1:       begin e_r = 1; pass = 0; spur = 1; end
            2:       if (model_occ > 0) x_r = 1; else e_r = 1;
            3:       begin e_r = 1; x_r = 1; end
            4:       begin
                         obs = 1;
                         if (model_occ > 0 && $urandom_range(0, 1) == 1) x_r = 1; else e_r = 1;
                     end
            default: e_r = 1;
        endcase
        if (x_r && model_occ > 0) begin
            nocc = model_occ - 1;
        end else if (model_occ < CAP) begin
            nocc = model_occ + 1;
        end else begin
            r.deny = 1; r.occ = model_occ; r.full = 1; r.phases = 0; r.open_ticks = -1;
            expq.push_back(r);
            entry_req = 1'b1;
            cycles(20);
            chk("deny_motor_still", int'(motor), 0);
            entry_req = 1'b0;
            cycles(3);
            return;
        end
        if (!pass) nocc = model_occ;
        r.deny = 0; r.occ = nocc; r.full = (nocc == CAP);
        r.phases = obs ? 2 : 1;
        r.open_ticks = (pass && !obs) ? -1 : HOLD;
        expq.push_back(r);

        entry_req = e_r; exit_req = x_r;
        wait_for(0, 5, "start_opening");
        entry_req = 1'b0; exit_req = 1'b0;
        if (spur) begin
            car_passed = 1'b1;
            cycles(1);
            car_passed = 1'b0;
        end
        wait_for(1, 4 * T1, "reach_open");
        if (pass) begin
            cycles($urandom_range(1, T1));
            car_passed = 1'b1;
            cycles(2);
            car_passed = 1'b0;
        end
        if (obs) begin
            wait_for(2, 4 * T1, "reach_closing");
            cycles($urandom_range(0, T1 / 2));
            obstruct = 1'b1;
            cycles(1);
            obstruct = 1'b0;
        end
        wait_for(3, 20 * T1, "back_idle");
        model_occ = nocc;
        cycles($urandom_range(1, 5));
    endtask

    int directed[7] = '{1, 0, 0, 5, 2, 3, 4};

    initial begin
        cycles(3);
        check_zero("reset");
        reset_n = 1'b1;
        cycles(2);

        foreach (directed[i]) do_txn(directed[i]);
        for (int i = 0; i < 20; i++) do_txn($urandom_range(0, 5));

        // Abandon a gate cycle mid-OPEN with reset; occupancy must clear.
        if (model_occ < CAP) entry_req = 1'b1; else exit_req = 1'b1;
        wait_for(0, 5, "rst_start_opening");
        entry_req = 1'b0; exit_req = 1'b0;
        wait_for(1, 4 * T1, "rst_reach_open");
        cycles(3);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("reset_mid_open");
        cycles(4);
        reset_n = 1'b1;
        model_occ = 0;
        cycles(2);

        for (int i = 0; i < 4; i++) do_txn($urandom_range(0, 5));

        cycles(5);
        chk("scoreboard_drained", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
